// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: opcodes, funct3 codes, FSM states
// and immediate extraction helpers.
package branch_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // BRANCH conditions; 010 and 011 are unassigned and decode as illegal.
   typedef enum logic [2:0] {
      F3_EQ  = 3'b000,
      F3_NE  = 3'b001,
      F3_LT  = 3'b100,
      F3_GE  = 3'b101,
      F3_LTU = 3'b110,
      F3_GEU = 3'b111
   } funct3_e;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_RESOLVE = 1'b1
   } state_e;

   function automatic logic is_cf(input logic [6:0] opc);
      return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return {{21{i[31]}}, i[30:20]};
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Bus between the pc/fetch side (master) and the branch unit (slave).
// Protocol: there is no valid/ready pair. A control-flow opcode on INSTR in
// IDLE is the request and is always accepted; the unit answers in the next
// cycle (RESOLVE) while the pc stalls and re-presents the same instruction,
// which the unit ignores and flags dead with KILL.
interface branch_unit_if
   import branch_pkg::*;
#(
   parameter int CW = 32
);
   logic [31:0]   INSTR;
   logic [31:0]   IP;
   logic [31:0]   RS1_DATA;
   logic [31:0]   RS2_DATA;
   logic [6:0]    OP;
   logic [31:0]   up_amt;
   logic          b_taken;
   logic          LINK_WE;
   logic [4:0]    LINK_RD;
   logic [31:0]   LINK_DATA;
   logic          KILL;
   logic          MISALIGN;
   logic          ILLEGAL;
   logic [CW-1:0] BR_CNT;
   logic [CW-1:0] TAKEN_CNT;
   state_e        STATE_DBG;

   modport master (
      output INSTR, IP, RS1_DATA, RS2_DATA,
      input  OP, up_amt, b_taken, LINK_WE, LINK_RD, LINK_DATA,
      input  KILL, MISALIGN, ILLEGAL, BR_CNT, TAKEN_CNT, STATE_DBG
   );

   modport slave (
      input  INSTR, IP, RS1_DATA, RS2_DATA,
      output OP, up_amt, b_taken, LINK_WE, LINK_RD, LINK_DATA,
      output KILL, MISALIGN, ILLEGAL, BR_CNT, TAKEN_CNT, STATE_DBG
   );
endinterface

// File: rtl/branch_cmp.sv
// Combinational BRANCH condition evaluator.
module branch_cmp
   import branch_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        taken_o,
   output logic        illegal_o
);

   // Evaluate the condition selected by funct3; unassigned codes never take.
   always_comb begin
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      case (funct3_i)
         F3_EQ:   taken_o = (a_i == b_i);
         F3_NE:   taken_o = (a_i != b_i);
         F3_LT:   taken_o = ($signed(a_i) <  $signed(b_i));
         F3_GE:   taken_o = ($signed(a_i) >= $signed(b_i));
         F3_LTU:  taken_o = (a_i <  b_i);
         F3_GEU:  taken_o = (a_i >= b_i);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Decode-stage control-flow resolver: accepts JAL/JALR/BRANCH in IDLE,
// resolves from latched operands in the following RESOLVE cycle.
module branch_unit
   import branch_pkg::*;
#(
   parameter int CW = 32
)(
   input  logic         CLK,
   input  logic         RESET_N,
   branch_unit_if.slave bus
);

   state_e        state_q, state_d;
   logic [31:0]   ip_q, instr_q, rs1_q, rs2_q;
   logic [CW-1:0] br_cnt_q, br_cnt_d, taken_cnt_q, taken_cnt_d;

   logic          resolving;
   logic          accept;
   logic [6:0]    opc_q;
   logic [4:0]    rd_q;
   logic          cmp_taken, cmp_illegal;
   logic          res_taken, res_link, res_illegal;
   logic [31:0]   res_off;
   logic [31:0]   jalr_tgt;
   logic [31:0]   target;

   assign resolving = (state_q == S_RESOLVE);
   assign accept    = (state_q == S_IDLE) && is_cf(bus.INSTR[6:0]);
   assign opc_q     = instr_q[6:0];
   assign rd_q      = instr_q[11:7];

   // State, operand latches and statistics; reset drops any pending resolution.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         ip_q        <= '0;
         instr_q     <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
         if (accept) begin
            ip_q    <= bus.IP;
            instr_q <= bus.INSTR;
            rs1_q   <= bus.RS1_DATA;
            rs2_q   <= bus.RS2_DATA;
         end
      end
   end

   // Next state: RESOLVE lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept) state_d = S_RESOLVE;
         S_RESOLVE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   branch_cmp u_cmp (
      .funct3_i  (instr_q[14:12]),
      .a_i       (rs1_q),
      .b_i       (rs2_q),
      .taken_o   (cmp_taken),
      .illegal_o (cmp_illegal)
   );

   // JALR clears bit 0 of the absolute target, then re-expresses it as an offset.
   assign jalr_tgt = (rs1_q + imm_i(instr_q)) & ~32'd1;

   // Resolution of the latched instruction: direction, offset, link request.
   always_comb begin
      res_taken   = 1'b0;
      res_link    = 1'b0;
      res_illegal = 1'b0;
      res_off     = '0;
      case (opc_q)
         OPC_BRANCH: begin
            res_illegal = cmp_illegal;
            if (cmp_taken) begin
               res_taken = 1'b1;
               res_off   = imm_b(instr_q);
            end
         end
         OPC_JAL: begin
            res_taken = 1'b1;
            res_link  = 1'b1;
            res_off   = imm_j(instr_q);
         end
         OPC_JALR: begin
            res_taken = 1'b1;
            res_link  = 1'b1;
            res_off   = jalr_tgt - ip_q;
         end
         default: ;
      endcase
   end

   assign target = ip_q + res_off;

   // Counters advance on the RESOLVE->IDLE edge only.
   always_comb begin
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (resolving) begin
         br_cnt_d = br_cnt_q + CW'(1);
         if (res_taken) taken_cnt_d = taken_cnt_q + CW'(1);
      end
   end

   assign bus.OP        = resolving ? 7'b0 : bus.INSTR[6:0];
   assign bus.b_taken   = resolving & res_taken;
   assign bus.up_amt    = resolving ? res_off : 32'd0;
   assign bus.LINK_WE   = resolving & res_link & (rd_q != 5'd0);
   assign bus.LINK_RD   = (resolving & res_link) ? rd_q : 5'd0;
   assign bus.LINK_DATA = (resolving & res_link) ? (ip_q + 32'd4) : 32'd0;
   assign bus.KILL      = resolving;
   assign bus.MISALIGN  = resolving & res_taken & target[1];
   assign bus.ILLEGAL   = resolving & res_illegal;
   assign bus.BR_CNT    = br_cnt_q;
   assign bus.TAKEN_CNT = taken_cnt_q;
   assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with hand-computed expectations.
module tb_branch_unit;
   import branch_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [31:0] exp_br;
   logic [31:0] exp_tk;

   branch_unit_if #(.CW(32)) bus ();

   branch_unit #(.CW(32)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a control-flow op in IDLE, check the IDLE cycle, then stop at
   // the RESOLVE negedge with scrambled operands on the bus.
   task automatic do_cf(input string name, input logic [31:0] ins, input logic [31:0] ip,
                        input logic [31:0] r1, input logic [31:0] r2);
      @(posedge clk); #1;
      bus.INSTR = ins; bus.IP = ip; bus.RS1_DATA = r1; bus.RS2_DATA = r2;
      @(negedge clk);
      check({name, ".idle_op"},    {25'd0, bus.OP}, {25'd0, ins[6:0]});
      check({name, ".idle_taken"}, {31'd0, bus.b_taken}, 32'd0);
      check({name, ".idle_br"},    bus.BR_CNT, exp_br);
      check({name, ".idle_tk"},    bus.TAKEN_CNT, exp_tk);
      @(posedge clk); #1;
      bus.RS1_DATA = ~r1; bus.RS2_DATA = ~r2; bus.IP = ip + 32'd4;
      @(negedge clk);
   endtask

   task automatic chk_res(input string name, input logic e_tk, input logic [31:0] e_amt,
                          input logic e_lwe, input logic [4:0] e_rd, input logic [31:0] e_ld,
                          input logic e_mis, input logic e_ill);
      check({name, ".b_taken"},   {31'd0, bus.b_taken}, {31'd0, e_tk});
      check({name, ".up_amt"},    bus.up_amt, e_amt);
      check({name, ".link_we"},   {31'd0, bus.LINK_WE}, {31'd0, e_lwe});
      check({name, ".link_rd"},   {27'd0, bus.LINK_RD}, {27'd0, e_rd});
      check({name, ".link_data"}, bus.LINK_DATA, e_ld);
      check({name, ".misalign"},  {31'd0, bus.MISALIGN}, {31'd0, e_mis});
      check({name, ".illegal"},   {31'd0, bus.ILLEGAL}, {31'd0, e_ill});
      check({name, ".kill"},      {31'd0, bus.KILL}, 32'd1);
      check({name, ".op"},        {25'd0, bus.OP}, 32'd0);
      exp_br = exp_br + 32'd1;
      if (e_tk) exp_tk = exp_tk + 32'd1;
   endtask

   task automatic idle_nop(input string name);
      @(posedge clk); #1;
      bus.INSTR = NOP;
      @(negedge clk);
      check({name, ".br_cnt"},  bus.BR_CNT, exp_br);
      check({name, ".tk_cnt"},  bus.TAKEN_CNT, exp_tk);
      check({name, ".b_taken"}, {31'd0, bus.b_taken}, 32'd0);
      check({name, ".kill"},    {31'd0, bus.KILL}, 32'd0);
      check({name, ".illegal"}, {31'd0, bus.ILLEGAL}, 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; exp_br = '0; exp_tk = '0;
      rst_n = 1'b0;
      bus.INSTR = NOP; bus.IP = '0; bus.RS1_DATA = '0; bus.RS2_DATA = '0;

      // Reset with random inputs, including a BRANCH opcode.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         bus.INSTR = {$urandom()} & 32'hFFFF_FF80 | {25'd0, OPC_BRANCH};
         bus.IP = $urandom(); bus.RS1_DATA = $urandom(); bus.RS2_DATA = $urandom();
         @(negedge clk);
         check("rst.b_taken",   {31'd0, bus.b_taken}, 32'd0);
         check("rst.up_amt",    bus.up_amt, 32'd0);
         check("rst.link_we",   {31'd0, bus.LINK_WE}, 32'd0);
         check("rst.link_data", bus.LINK_DATA, 32'd0);
         check("rst.kill",      {31'd0, bus.KILL}, 32'd0);
         check("rst.misalign",  {31'd0, bus.MISALIGN}, 32'd0);
         check("rst.illegal",   {31'd0, bus.ILLEGAL}, 32'd0);
         check("rst.br_cnt",    bus.BR_CNT, 32'd0);
         check("rst.tk_cnt",    bus.TAKEN_CNT, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.INSTR = 32'h0000_10B7;  // lui: not control flow
      @(negedge clk);
      check("rel.op", {25'd0, bus.OP}, 32'h37);
      @(posedge clk); #1;
      @(negedge clk);
      check("rel.stay_idle_kill", {31'd0, bus.KILL}, 32'd0);
      check("rel.op2", {25'd0, bus.OP}, 32'h37);

      // beq x1,x2,+16 with equal operands.
      do_cf("beq", 32'h0020_8863, 32'h100, 32'd5, 32'd5);
      chk_res("beq", 1'b1, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      idle_nop("beq_after");

      // bne with equal operands: not taken.
      do_cf("bne", 32'h0020_9863, 32'h100, 32'd5, 32'd5);
      chk_res("bne", 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

      // blt / bltu back to back: -1 < 1 signed, not unsigned.
      do_cf("blt", 32'h0020_C863, 32'h100, 32'hFFFF_FFFF, 32'd1);
      chk_res("blt", 1'b1, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      do_cf("bltu", 32'h0020_E863, 32'h100, 32'hFFFF_FFFF, 32'd1);
      chk_res("bltu", 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      idle_nop("bltu_after");

      // jal x1,-8 at 0x200.
      do_cf("jal", 32'hFF9F_F0EF, 32'h200, 32'd0, 32'd0);
      chk_res("jal", 1'b1, 32'hFFFF_FFF8, 1'b1, 5'd1, 32'h204, 1'b0, 1'b0);

      // jalr x5,3(x6): target 0x1004, offset 0xFC4.
      do_cf("jalr3", 32'h0033_02E7, 32'h40, 32'h1001, 32'd0);
      chk_res("jalr3", 1'b1, 32'hFC4, 1'b1, 5'd5, 32'h44, 1'b0, 1'b0);

      // jalr x5,2(x6): target 0x1002 has bit1 set.
      do_cf("jalr2", 32'h0023_02E7, 32'h40, 32'h1000, 32'd0);
      chk_res("jalr2", 1'b1, 32'hFC2, 1'b1, 5'd5, 32'h44, 1'b1, 1'b0);
      idle_nop("jalr_after");

      // jal x0,-8: redirect without link write.
      do_cf("jal_x0", 32'hFF9F_F06F, 32'h200, 32'd0, 32'd0);
      chk_res("jal_x0", 1'b1, 32'hFFFF_FFF8, 1'b0, 5'd0, 32'h204, 1'b0, 1'b0);

      // funct3 010 on BRANCH: illegal, not taken.
      do_cf("f3_010", 32'h0020_A863, 32'h100, 32'd5, 32'd5);
      chk_res("f3_010", 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      idle_nop("ill_after");

      // Reset asserted during RESOLVE drops the resolution.
      do_cf("rst_mid", 32'h0020_8863, 32'h100, 32'd5, 32'd5);
      check("rst_mid.pre_taken", {31'd0, bus.b_taken}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.INSTR = NOP;
      exp_br = '0; exp_tk = '0;
      @(negedge clk);
      check("rst_mid.b_taken", {31'd0, bus.b_taken}, 32'd0);
      check("rst_mid.kill",    {31'd0, bus.KILL}, 32'd0);
      check("rst_mid.br_cnt",  bus.BR_CNT, exp_br);
      check("rst_mid.tk_cnt",  bus.TAKEN_CNT, exp_tk);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_mid.br_cnt2", bus.BR_CNT, exp_br);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
